// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } arb_state_e;

  localparam int CNT_W = 8;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N_REQ.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic             any_req,
  output logic [IW-1:0]    win
);

  logic [IW:0] sum;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    any_req = |req;
    win     = '0;
    sum     = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      sum = {1'b0, ptr} + (IW+1)'(off);
      if (sum >= (IW+1)'(N_REQ)) sum = sum - (IW+1)'(N_REQ);
      if (req[sum[IW-1:0]]) win = sum[IW-1:0];
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among N_REQ producers.
//   state   | meaning
//   S_IDLE  | no grant; arbitrate among valid producers this cycle
//   S_BURST | grant locked to grant_id until last, MAX_BURST beats or stall timeout
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int D_WIDTH   = 48,
  parameter int MAX_BURST = 8,
  parameter int IDLE_TMO  = 16,
  localparam int IW       = idx_w(N_REQ)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [N_REQ-1:0]         i_req_valid,
  input  logic [N_REQ-1:0]         i_req_last,
  input  logic [N_REQ*D_WIDTH-1:0] i_req_data,
  output logic [N_REQ-1:0]         o_req_ready,
  input  logic                     i_fifo_full,
  input  logic                     i_fifo_almst_full,
  output logic                     o_fifo_wr_en,
  output logic [D_WIDTH-1:0]       o_fifo_data,
  output logic [IW-1:0]            o_grant_id,
  output logic                     o_busy
);

  arb_state_e         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      grant_id;
  logic [IW-1:0]      pick_id;
  logic [IW-1:0]      ptr_next;
  logic [CNT_W-1:0]   beat_cnt;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               any_req;
  logic               throttle;
  logic               g_valid;
  logic               g_last;
  logic [D_WIDTH-1:0] g_data;
  logic               xfer;
  logic               stall;
  logic               burst_end;
  logic               tmo_hit;

  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_rr_pick (
    .req     (i_req_valid),
    .ptr     (rr_ptr),
    .any_req (any_req),
    .win     (pick_id)
  );

  // Almost-full already leaves room for the beat sitting in the output register.
  assign throttle  = i_fifo_full | i_fifo_almst_full;
  assign g_valid   = i_req_valid[grant_id];
  assign g_last    = i_req_last[grant_id];
  assign g_data    = i_req_data[grant_id*D_WIDTH +: D_WIDTH];
  assign xfer      = (state == S_BURST) & g_valid & ~throttle;
  assign stall     = (state == S_BURST) & ~g_valid & ~throttle;
  assign burst_end = xfer & (g_last | ((beat_cnt + CNT_W'(1)) == CNT_W'(MAX_BURST)));
  assign tmo_hit   = stall & ((tmo_cnt + CNT_W'(1)) == CNT_W'(IDLE_TMO));
  assign ptr_next  = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + IW'(1);
  assign o_grant_id = grant_id;

  always_comb begin
    o_req_ready = '0;
    if (state == S_BURST && !throttle) o_req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      grant_id     <= '0;
      beat_cnt     <= '0;
      tmo_cnt      <= '0;
      o_busy       <= 1'b0;
      o_fifo_wr_en <= 1'b0;
      o_fifo_data  <= '0;
    end else begin
      o_fifo_wr_en <= xfer;
      if (xfer) o_fifo_data <= g_data;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            grant_id <= pick_id;
            beat_cnt <= '0;
            tmo_cnt  <= '0;
            state    <= S_BURST;
            o_busy   <= 1'b1;
          end
        end
        S_BURST: begin
          if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
            tmo_cnt  <= '0;
          end else if (stall) begin
            tmo_cnt  <= tmo_cnt + CNT_W'(1);
          end
          if (burst_end | tmo_hit) begin
            rr_ptr <= ptr_next;
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and random bench for fifo_wr_arbiter with per-producer scoreboards.
module tb_fifo_wr_arbiter;

  localparam int N   = 4;
  localparam int DW  = 48;
  localparam int MB  = 8;
  localparam int TMO = 16;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [N-1:0]    i_req_valid = '0;
  logic [N-1:0]    i_req_last = '0;
  logic [N*DW-1:0] i_req_data = '0;
  logic [N-1:0]    o_req_ready;
  logic            i_fifo_full = 1'b0;
  logic            i_fifo_almst_full = 1'b0;
  logic            o_fifo_wr_en;
  logic [DW-1:0]   o_fifo_data;
  logic [1:0]      o_grant_id;
  logic            o_busy;

  fifo_wr_arbiter #(
    .N_REQ     (N),
    .D_WIDTH   (DW),
    .MAX_BURST (MB),
    .IDLE_TMO  (TMO)
  ) dut (
    .i_clk             (i_clk),
    .i_rst_n           (i_rst_n),
    .i_req_valid       (i_req_valid),
    .i_req_last        (i_req_last),
    .i_req_data        (i_req_data),
    .o_req_ready       (o_req_ready),
    .i_fifo_full       (i_fifo_full),
    .i_fifo_almst_full (i_fifo_almst_full),
    .o_fifo_wr_en      (o_fifo_wr_en),
    .o_fifo_data       (o_fifo_data),
    .o_grant_id        (o_grant_id),
    .o_busy            (o_busy)
  );

  always #5 i_clk = ~i_clk;

  logic [DW-1:0] src_q[N][$];
  logic [DW-1:0] exp_q[N][$];
  int            acc_cnt[N];
  int            wr_log[$];
  int            grant_log[$];
  int            gap_log[$];
  bit            gaps;
  bit            gran_en;
  bit            seen_grant;
  bit            prev_busy;
  bit            open_burst;
  int            idle_run;
  int            cur_id;
  int            cur_cnt;
  int            mon_id;
  int            mon_avail;
  int            n_checks;
  int            n_errors;
  int            seq;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Beat layout: [47:44] producer, [43] last, [31:0] global sequence number.
  task automatic push_burst(input int k, input int len, input bit with_last);
    logic [DW-1:0] d;
    for (int i = 0; i < len; i++) begin
      d = {4'(k), 1'(with_last && (i == len - 1)), 11'd0, 32'(seq)};
      seq++;
      src_q[k].push_back(d);
      exp_q[k].push_back(d);
    end
  endtask

  task automatic clear_logs();
    wr_log.delete();
    grant_log.delete();
    gap_log.delete();
    seen_grant = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input bit rflags, input string tag);
    int  n;
    bit  empty;
    n = 0;
    forever begin
      empty = 1'b1;
      for (int k = 0; k < N; k++)
        if (src_q[k].size() != 0 || exp_q[k].size() != 0) empty = 1'b0;
      if ((empty && !o_busy) || n >= budget) break;
      @(negedge i_clk);
      if (rflags) begin
        i_fifo_almst_full = ($urandom_range(7) == 0);
        i_fifo_full       = ($urandom_range(15) == 0);
      end
      n++;
    end
    i_fifo_almst_full = 1'b0;
    i_fifo_full       = 1'b0;
    chk({tag, "_drain_timeout"}, 64'(n >= budget), 0);
  endtask

  task automatic wait_acc(input int k, input int target, input string tag);
    int n;
    n = 0;
    while (acc_cnt[k] < target && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk({tag, "_wait_timeout"}, 64'(n >= 300), 0);
  endtask

  // Producer model: pops a beat on the edge that accepts it, then presents the next one.
  always begin : bfm
    logic [N-1:0] acc;
    @(posedge i_clk);
    acc = i_req_valid & o_req_ready;
    #1;
    for (int k = 0; k < N; k++) begin
      if (acc[k] && src_q[k].size() > 0) begin
        void'(src_q[k].pop_front());
        acc_cnt[k]++;
      end
      if (src_q[k].size() > 0) begin
        i_req_valid[k]           = gaps ? ($urandom_range(3) != 0) : 1'b1;
        i_req_data[k*DW +: DW]   = src_q[k][0];
        i_req_last[k]            = src_q[k][0][43];
      end else begin
        i_req_valid[k] = 1'b0;
        i_req_last[k]  = 1'b0;
      end
    end
  end

  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      seen_grant = 1'b0;
      prev_busy  = 1'b0;
      open_burst = 1'b0;
      idle_run   = 0;
    end else begin
      chk("ready_onehot", 64'($countones(o_req_ready) <= 1), 1);
      if (!o_busy) chk("ready_when_idle", o_req_ready, 0);
      if (o_busy) begin
        if (!prev_busy) begin
          if (seen_grant) gap_log.push_back(idle_run);
          grant_log.push_back(int'(o_grant_id));
          seen_grant = 1'b1;
        end
        idle_run = 0;
      end else begin
        idle_run++;
      end
      prev_busy = o_busy;
      if (!gran_en) open_burst = 1'b0;
      if (o_fifo_wr_en) begin
        mon_id = int'(o_fifo_data[47:44]);
        wr_log.push_back(mon_id);
        mon_avail = (mon_id < N) ? exp_q[mon_id].size() : 0;
        chk("wr_has_expected", 64'(mon_avail != 0), 1);
        if (mon_avail != 0) chk("wr_data", o_fifo_data, exp_q[mon_id].pop_front());
        if (gran_en) begin
          if (open_burst) chk("burst_granularity", mon_id, cur_id);
          cur_cnt    = open_burst ? cur_cnt + 1 : 1;
          cur_id     = mon_id;
          open_burst = !(o_fifo_data[43] || cur_cnt == MB);
        end
      end
    end
  end

  initial begin
    int base;
    int total;
    int k;
    int len;
    int n;
    int exp_g1[5];
    int exp_g2[5];
    int exp_w[$];

    gaps    = 1'b0;
    gran_en = 1'b1;
    seq     = 1;

    // Reset values
    repeat (3) @(negedge i_clk);
    chk("rst_wr_en", o_fifo_wr_en, 0);
    chk("rst_data", o_fifo_data, 0);
    chk("rst_ready", o_req_ready, 0);
    chk("rst_grant", o_grant_id, 0);
    chk("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Round-robin fairness: 2-beat bursts from everyone, producer 0 twice
    clear_logs();
    for (int p = 0; p < N; p++) push_burst(p, 2, 1'b1);
    push_burst(0, 2, 1'b1);
    wait_drain(500, 1'b0, "t1");
    exp_g1 = '{0, 1, 2, 3, 0};
    chk("t1_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t1_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_g1[i]);
    chk("t1_write_count", wr_log.size(), 10);
    for (int i = 0; i < 10; i++)
      chk("t1_write_src", (i < wr_log.size()) ? wr_log[i] : -1, exp_g1[i/2]);
    chk("t1_gap_count", gap_log.size(), 4);
    for (int i = 0; i < gap_log.size(); i++) chk("t1_idle_gap", gap_log[i], 1);

    // MAX_BURST cap: 20 beats from producer 2 with no last, singles from 0 and 1
    gran_en = 1'b0;
    clear_logs();
    push_burst(2, 20, 1'b0);
    push_burst(0, 1, 1'b1);
    push_burst(1, 1, 1'b1);
    wait_drain(600, 1'b0, "t2");
    exp_g2 = '{1, 2, 0, 2, 2};
    chk("t2_grant_count", grant_log.size(), 5);
    for (int i = 0; i < 5; i++)
      chk("t2_grant_order", (i < grant_log.size()) ? grant_log[i] : -1, exp_g2[i]);
    exp_w.delete();
    exp_w.push_back(1);
    for (int i = 0; i < 8; i++) exp_w.push_back(2);
    exp_w.push_back(0);
    for (int i = 0; i < 12; i++) exp_w.push_back(2);
    chk("t2_write_count", wr_log.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      chk("t2_write_src", (i < wr_log.size()) ? wr_log[i] : -1, exp_w[i]);

    // Almost-full after 3 beats, then full alone
    base = acc_cnt[3];
    push_burst(3, 6, 1'b1);
    wait_acc(3, base + 3, "t3");
    i_fifo_almst_full = 1'b1;
    #1;
    chk("t3_ready_drop", o_req_ready, 0);
    chk("t3_beat3_written", o_fifo_wr_en, 1);
    repeat (20) begin
      @(negedge i_clk);
      chk("t3_no_write_throttled", o_fifo_wr_en, 0);
    end
    chk("t3_busy_held", o_busy, 1);
    chk("t3_accept_held", acc_cnt[3], base + 3);
    i_fifo_almst_full = 1'b0;
    #1;
    chk("t3_ready_back", o_req_ready, 4'b1000);
    @(negedge i_clk);
    chk("t3_resume_write", o_fifo_wr_en, 1);
    i_fifo_full = 1'b1;
    #1;
    chk("t3_full_ready", o_req_ready, 0);
    @(negedge i_clk);
    chk("t3_full_no_write", o_fifo_wr_en, 0);
    i_fifo_full = 1'b0;
    wait_drain(300, 1'b0, "t3");

    // Timeout abandon: producer 1 sends one beat and goes quiet
    base = acc_cnt[1];
    push_burst(1, 1, 1'b0);
    wait_acc(1, base + 1, "t4");
    chk("t4_grant_is_1", o_grant_id, 1);
    push_burst(2, 2, 1'b1);
    n = 0;
    while (o_busy && n < 40) begin
      n++;
      @(negedge i_clk);
    end
    chk("t4_timeout_cycles", n, TMO);
    @(negedge i_clk);
    chk("t4_next_busy", o_busy, 1);
    chk("t4_next_grant", o_grant_id, 2);
    wait_drain(300, 1'b0, "t4");

    // Reset during beat 3 of 5
    clear_logs();
    base = acc_cnt[2];
    push_burst(2, 5, 1'b1);
    wait_acc(2, base + 2, "t5");
    i_rst_n = 1'b0;
    @(negedge i_clk);
    chk("t5_wr_en", o_fifo_wr_en, 0);
    chk("t5_data", o_fifo_data, 0);
    chk("t5_ready", o_req_ready, 0);
    chk("t5_grant", o_grant_id, 0);
    chk("t5_busy", o_busy, 0);
    src_q[2].delete();
    exp_q[2].delete();
    push_burst(1, 2, 1'b1);
    push_burst(3, 2, 1'b1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    wait_drain(300, 1'b0, "t5");
    chk("t5_pre_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 2);
    chk("t5_post_grant_first", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
    chk("t5_post_grant_second", (grant_log.size() > 2) ? grant_log[2] : -1, 3);

    // Random bursts, valid gaps and flag noise, 1000 beats
    gaps    = 1'b1;
    gran_en = 1'b1;
    clear_logs();
    total = 0;
    while (total < 1000) begin
      k   = $urandom_range(N - 1);
      len = $urandom_range(12, 1);
      if (total + len > 1000) len = 1000 - total;
      push_burst(k, len, 1'b1);
      total += len;
    end
    wait_drain(30000, 1'b1, "t6");
    chk("t6_write_count", wr_log.size(), 1000);
    gaps = 1'b0;

    repeat (2) @(negedge i_clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
